// File: rtl/lock_pkg.sv
// Shared lock types: code width, button indices, lock FSM state encoding.
// Used by the input conditioner and by the downstream lock FSM.
package lock_pkg;

    localparam int CODE_W    = 7;
    localparam int BTN_SET   = 0;
    localparam int BTN_ENTER = 1;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_SET_AWAITING   = 3'd1,
        ST_OPENED         = 3'd2,
        ST_ALARM          = 3'd3,
        ST_INPUT_PASSWORD = 3'd4
    } lock_state_e;

    // Bits needed to hold a count of 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lock_input_conditioner_if.sv
// Pad-side inputs and conditioned event outputs of the lock input stage.
// master drives the raw pads; slave is the conditioner.
interface lock_input_conditioner_if #(
    parameter int N_BTN  = 2,
    parameter int CODE_W = lock_pkg::CODE_W
);

    logic [N_BTN-1:0]  btn_raw;
    logic [CODE_W-1:0] code_raw;
    logic [N_BTN-1:0]  btn_level;
    logic [N_BTN-1:0]  btn_press;
    logic [N_BTN-1:0]  btn_release;
    logic [CODE_W-1:0] code_snap;
    logic              code_stable;
    logic [N_BTN-1:0]  btn_long;

    modport master (
        output btn_raw, code_raw,
        input  btn_level, btn_press, btn_release,
        input  code_snap, code_stable, btn_long
    );

    modport slave (
        input  btn_raw, code_raw,
        output btn_level, btn_press, btn_release,
        output code_snap, code_stable, btn_long
    );

endinterface

// File: rtl/btn_debounce.sv
// One button: synchroniser, debounce counter, edge pulses.
// Long-press hold counter only when LONG_PRESS_EN is defined.
module btn_debounce
    import lock_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 1000
`ifdef LONG_PRESS_EN
    ,
    parameter int LONG_CYC     = 50000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic unpress,
    output logic press_nxt,
    output logic long_press
);

    localparam int CW = cnt_w(DEBOUNCE_CYC);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   synced;
    logic                   toggle;

    assign synced    = sync_q[SYNC_STAGES-1];
    assign toggle    = (synced != level) && (cnt == TERM);
    assign press_nxt = toggle && !level;

    // Plain flop chain, nothing between stages.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end

    // Qualify a level change; any return to level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
            unpress <= 1'b0;
        end else begin
            press   <= toggle && !level;
            unpress <= toggle && level;
            if (synced == level || toggle) cnt <= '0;
            else                           cnt <= cnt + 1'b1;
            if (toggle) level <= ~level;
        end
    end

`ifdef LONG_PRESS_EN
    localparam int HW = cnt_w(LONG_CYC);
    localparam logic [HW-1:0] HTERM = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] HSAT  = HW'(LONG_CYC);

    logic [HW-1:0] hcnt;
    logic          long_q;

    assign long_press = long_q;

    // Hold counter saturates past terminal so a held button fires once.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt   <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= level && (hcnt == HTERM);
            if (!level)            hcnt <= '0;
            else if (hcnt != HSAT) hcnt <= hcnt + 1'b1;
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/lock_input_conditioner.sv
// Lock input stage: per-button debounce plus code snapshot and stability.
// Optional long-press events: define LONG_PRESS_EN.
module lock_input_conditioner #(
    parameter int N_BTN        = 2,
    parameter int CODE_W       = lock_pkg::CODE_W,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int LONG_CYC     = 50000
) (
    input logic                     clk,
    input logic                     rst,
    lock_input_conditioner_if.slave bus
);

    import lock_pkg::*;

    localparam int SW = cnt_w(DEBOUNCE_CYC);
    localparam logic [SW-1:0] STERM = SW'(DEBOUNCE_CYC - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYC < 1 || LONG_CYC < 1) begin : g_bad_param
        $error("lock_input_conditioner: bad parameter");
    end

    logic [N_BTN-1:0]  press_nxt;
    logic [CODE_W-1:0] code_sync_q [SYNC_STAGES];
    logic [CODE_W-1:0] code_sync;
    logic [CODE_W-1:0] code_prev_q;
    logic [SW-1:0]     scnt;
    logic [CODE_W-1:0] snap_q;
    logic              stable_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
`ifdef LONG_PRESS_EN
            ,
            .LONG_CYC     (LONG_CYC)
`endif
        ) u_btn (
            .clk        (clk),
            .rst        (rst),
            .btn_raw    (bus.btn_raw[i]),
            .level      (bus.btn_level[i]),
            .press      (bus.btn_press[i]),
            .unpress    (bus.btn_release[i]),
            .press_nxt  (press_nxt[i]),
            .long_press (bus.btn_long[i])
        );
    end

    assign code_sync       = code_sync_q[SYNC_STAGES-1];
    assign bus.code_snap   = snap_q;
    assign bus.code_stable = stable_q;

    // Code switch synchroniser, one flop chain per bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) code_sync_q[i] <= '0;
        end else begin
            code_sync_q[0] <= bus.code_raw;
            for (int i = 1; i < SYNC_STAGES; i++) code_sync_q[i] <= code_sync_q[i-1];
        end
    end

    // Stable flag: drop on any change, rise after a quiet window.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_prev_q <= '0;
            scnt        <= '0;
            stable_q    <= 1'b0;
        end else begin
            code_prev_q <= code_sync;
            if (code_sync != code_prev_q) begin
                scnt     <= '0;
                stable_q <= 1'b0;
            end else if (scnt == STERM) begin
                stable_q <= 1'b1;
            end else begin
                scnt <= scnt + 1'b1;
            end
        end
    end

    // Snapshot lands together with the press pulse.
    always_ff @(posedge clk) begin
        if (rst)             snap_q <= '0;
        else if (|press_nxt) snap_q <= code_sync;
    end

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Bench for lock_input_conditioner: event scoreboard plus direct checks.
// Define LONG_PRESS_EN to exercise the long-press events.
module tb_lock_input_conditioner;

    localparam int NB  = 2;
    localparam int CW  = 7;
    localparam int D   = 4;
    localparam int S   = 2;
    localparam int L   = 10;
    localparam int LAT = S + D;

    typedef struct {
        int           at;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] lng;
        logic [NB-1:0] lvl;
        logic [CW-1:0] snap;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    ev_t           sb[$];
    logic [NB-1:0] m_lvl  = '0;
    logic [CW-1:0] m_snap = '0;
    logic [CW-1:0] m_code = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lock_input_conditioner_if #(.N_BTN(NB), .CODE_W(CW)) bus ();

    lock_input_conditioner #(
        .N_BTN        (NB),
        .CODE_W       (CW),
        .SYNC_STAGES  (S),
        .DEBOUNCE_CYC (D),
        .LONG_CYC     (L)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int at, input logic [NB-1:0] p,
                        input logic [NB-1:0] r, input logic [NB-1:0] lg);
        ev_t e;
        m_lvl = (m_lvl | p) & ~r;
        if (p != '0) m_snap = m_code;
        e.at = at; e.press = p; e.rel = r; e.lng = lg;
        e.lvl = m_lvl; e.snap = m_snap;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin : mon
        ev_t e;
        if (!rst && (bus.btn_press != '0 || bus.btn_release != '0 || bus.btn_long != '0)) begin
            if (sb.size() == 0) begin
                chk("spurious_event", {bus.btn_press, bus.btn_release, bus.btn_long}, 0);
            end else begin
                e = sb.pop_front();
                chk("ev_cycle", cyc, e.at);
                chk("ev_press", bus.btn_press, e.press);
                chk("ev_release", bus.btn_release, e.rel);
                chk("ev_long", bus.btn_long, e.lng);
                chk("ev_level", bus.btn_level, e.lvl);
                chk("ev_snap", bus.code_snap, e.snap);
            end
        end
    end

    initial begin : stim
        int c;
        bus.btn_raw  = 2'b11;
        bus.code_raw = '0;

        // 1: reset with both buttons already held
        repeat (3) begin
            @(negedge clk);
            chk("rst_outputs", {bus.btn_level, bus.btn_press, bus.btn_release,
                                bus.btn_long, bus.code_snap, bus.code_stable}, 0);
        end
        c = cyc;
        rst = 1'b0;
        push(c + LAT, 2'b11, 2'b00, 2'b00);
        @(negedge clk);
        chk("post_rst_outputs", {bus.btn_level, bus.btn_press, bus.btn_release,
                                 bus.btn_long, bus.code_snap, bus.code_stable}, 0);
        tick(7);
        c = cyc;
        bus.btn_raw = 2'b00;
        push(c + LAT, 2'b00, 2'b11, 2'b00);
        tick(LAT + 4);

        // 2: clean press of set, held well past the window
        c = cyc;
        bus.btn_raw = 2'b01;
        push(c + LAT, 2'b01, 2'b00, 2'b00);
`ifdef LONG_PRESS_EN
        push(c + LAT + L, 2'b00, 2'b00, 2'b01);
`endif
        tick(LAT + L + 2);
        c = cyc;
        bus.btn_raw = 2'b00;
        push(c + LAT, 2'b00, 2'b01, 2'b00);
        tick(LAT + 4);

        // 3: bounce 1,0,1,0 then hold 1
        bus.btn_raw = 2'b01; tick(1);
        bus.btn_raw = 2'b00; tick(1);
        bus.btn_raw = 2'b01; tick(1);
        bus.btn_raw = 2'b00; tick(1);
        c = cyc;
        bus.btn_raw = 2'b01;
        push(c + LAT, 2'b01, 2'b00, 2'b00);
        tick(8);
        c = cyc;
        bus.btn_raw = 2'b00;
        push(c + LAT, 2'b00, 2'b01, 2'b00);
        tick(LAT + 4);

        // 4: code snapshot and stability
        m_code = 7'h5A;
        bus.code_raw = 7'h5A;
        tick(10);
        chk("code_stable_settled", bus.code_stable, 1);
        c = cyc;
        bus.btn_raw = 2'b10;
        push(c + LAT, 2'b10, 2'b00, 2'b00);
        tick(8);
        chk("snap_5a", bus.code_snap, 7'h5A);
        c = cyc;
        bus.btn_raw = 2'b00;
        push(c + LAT, 2'b00, 2'b10, 2'b00);
        m_code = 7'h21;
        bus.code_raw = 7'h21;
        tick(2);
        chk("stable_before_sync", bus.code_stable, 1);
        tick(1);
        chk("stable_drop", bus.code_stable, 0);
        chk("snap_held", bus.code_snap, 7'h5A);
        tick(3);
        chk("stable_still_low", bus.code_stable, 0);
        tick(1);
        chk("stable_back", bus.code_stable, 1);
        tick(LAT);

        // 5: simultaneous press and release
        c = cyc;
        bus.btn_raw = 2'b11;
        push(c + LAT, 2'b11, 2'b00, 2'b00);
        tick(8);
        c = cyc;
        bus.btn_raw = 2'b00;
        push(c + LAT, 2'b00, 2'b11, 2'b00);
        tick(LAT + 4);

        // 6: long hold of enter
        c = cyc;
        bus.btn_raw = 2'b10;
        push(c + LAT, 2'b10, 2'b00, 2'b00);
`ifdef LONG_PRESS_EN
        push(c + LAT + L, 2'b00, 2'b00, 2'b10);
`endif
        for (int i = 0; i < 30; i++) begin
            tick(1);
`ifndef LONG_PRESS_EN
            chk("long_tied_low", bus.btn_long, 0);
`endif
        end
        chk("hold_level", bus.btn_level, 2'b10);
        c = cyc;
        bus.btn_raw = 2'b00;
        push(c + LAT, 2'b00, 2'b10, 2'b00);
        tick(LAT + 6);

        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
